// File: rtl/io_pkg.sv
// Shared defaults and helpers for the io_ctrl port controller.
package io_pkg;

    localparam int IO_WIDTH       = 8;
    localparam int IO_NPORTS      = 4;
    localparam int IO_SYNC_STAGES = 2;

    // Width of a port index; never below one bit.
    function automatic int port_idx_width(input int nports);
        return (nports <= 2) ? 1 : $clog2(nports);
    endfunction

endpackage

// File: rtl/io_sync.sv
// Multi-flop vector synchroniser; every bit of d_i crosses STAGES flops.
module io_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] stage_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/io_ctrl.sv
// CPU-facing IO port bank: registered outputs with strobes, synchronised inputs,
// sticky per-port change flags and a masked interrupt.
module io_ctrl
    import io_pkg::*;
#(
    parameter int WIDTH       = IO_WIDTH,
    parameter int NPORTS      = IO_NPORTS,
    parameter int SYNC_STAGES = IO_SYNC_STAGES,
    localparam int SEL_W      = port_idx_width(NPORTS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic                     re,
    input  logic [SEL_W-1:0]         sel_port,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [NPORTS*WIDTH-1:0]  in_ports,
    input  logic [NPORTS*WIDTH-1:0]  ine_ports,
    input  logic                     irq_mask_we,
    output logic [NPORTS*WIDTH-1:0]  out_ports,
    output logic [NPORTS-1:0]        out_strobe,
    output logic [WIDTH-1:0]         rdata,
    output logic [WIDTH-1:0]         rdata_e,
    output logic [NPORTS-1:0]        chg_flags,
    output logic                     irq
);

    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_W        = $clog2(PRIME_CYCLES + 1);

    logic [NPORTS*WIDTH-1:0] sync_main, sync_ext;
    logic [NPORTS*WIDTH-1:0] prev_main_q, prev_ext_q;
    logic [NPORTS*WIDTH-1:0] out_ports_q, out_ports_d;
    logic [NPORTS-1:0]       strobe_q, strobe_d;
    logic [NPORTS-1:0]       flags_q, flags_d;
    logic [NPORTS-1:0]       mask_q, mask_d;
    logic [NPORTS-1:0]       change, sel_onehot;
    logic                    irq_q, irq_d;
    logic [CNT_W-1:0]        prime_cnt_q, prime_cnt_d;
    logic                    priming;

    io_sync #(.W(NPORTS*WIDTH), .STAGES(SYNC_STAGES)) u_sync_main (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_ports),
        .q_o     (sync_main)
    );

    io_sync #(.W(NPORTS*WIDTH), .STAGES(SYNC_STAGES)) u_sync_ext (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (ine_ports),
        .q_o     (sync_ext)
    );

    assign sel_onehot = {{(NPORTS-1){1'b0}}, 1'b1} << sel_port;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        assign change[gi] = (|(sync_main[gi*WIDTH +: WIDTH] ^ prev_main_q[gi*WIDTH +: WIDTH]))
                          | (|(sync_ext[gi*WIDTH +: WIDTH]  ^ prev_ext_q[gi*WIDTH +: WIDTH]));
        assign out_ports_d[gi*WIDTH +: WIDTH] = (we && sel_onehot[gi]) ? wdata
                                              : out_ports_q[gi*WIDTH +: WIDTH];
    end

    // Flags stay quiet until the previous-sample registers hold real input values;
    // a new set beats a same-edge read acknowledge.
    always_comb begin
        priming     = (prime_cnt_q != CNT_W'(PRIME_CYCLES));
        prime_cnt_d = priming ? prime_cnt_q + 1'b1 : prime_cnt_q;
        strobe_d    = we ? sel_onehot : '0;
        mask_d      = irq_mask_we ? wdata[NPORTS-1:0] : mask_q;
        flags_d     = (flags_q & ~(re ? sel_onehot : '0)) | (priming ? '0 : change);
        irq_d       = |(flags_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_main_q <= '0;
            prev_ext_q  <= '0;
            out_ports_q <= '0;
            strobe_q    <= '0;
            flags_q     <= '0;
            mask_q      <= '0;
            irq_q       <= 1'b0;
            prime_cnt_q <= '0;
        end else begin
            prev_main_q <= sync_main;
            prev_ext_q  <= sync_ext;
            out_ports_q <= out_ports_d;
            strobe_q    <= strobe_d;
            flags_q     <= flags_d;
            mask_q      <= mask_d;
            irq_q       <= irq_d;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    assign out_ports  = out_ports_q;
    assign out_strobe = strobe_q;
    assign chg_flags  = flags_q;
    assign irq        = irq_q;
    assign rdata      = sync_main[sel_port*WIDTH +: WIDTH];
    assign rdata_e    = sync_ext[sel_port*WIDTH +: WIDTH];

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl: write table with a scoreboard queue, then
// hand-written sequences for reads, interrupts, set/clear collision and reset.
module tb_io_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we, re, irq_mask_we;
    logic [1:0]  sel_port;
    logic [7:0]  wdata;
    logic [31:0] in_ports, ine_ports;
    logic [31:0] out_ports;
    logic [3:0]  out_strobe, chg_flags;
    logic [7:0]  rdata, rdata_e;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic        mask_we;
        logic [1:0]  sel;
        logic [7:0]  wdata;
        logic [31:0] exp_ports;
        logic [3:0]  exp_strobe;
    } vec_t;

    typedef struct packed {
        logic [31:0] ports;
        logic [3:0]  strobe;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];

    io_ctrl #(.WIDTH(8), .NPORTS(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .we          (we),
        .re          (re),
        .sel_port    (sel_port),
        .wdata       (wdata),
        .in_ports    (in_ports),
        .ine_ports   (ine_ports),
        .irq_mask_we (irq_mask_we),
        .out_ports   (out_ports),
        .out_strobe  (out_strobe),
        .rdata       (rdata),
        .rdata_e     (rdata_e),
        .chg_flags   (chg_flags),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;

        vecs[0] = '{1'b1, 1'b0, 2'd2, 8'hA5, 32'h00A5_0000, 4'b0100};
        vecs[1] = '{1'b0, 1'b0, 2'd2, 8'h00, 32'h00A5_0000, 4'b0000};
        vecs[2] = '{1'b1, 1'b0, 2'd0, 8'h3C, 32'h00A5_003C, 4'b0001};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 8'hFF, 32'hFFA5_003C, 4'b1000};
        vecs[4] = '{1'b1, 1'b0, 2'd2, 8'h11, 32'hFF11_003C, 4'b0100};
        vecs[5] = '{1'b1, 1'b0, 2'd1, 8'h7E, 32'hFF11_7E3C, 4'b0010};
        vecs[6] = '{1'b0, 1'b0, 2'd1, 8'h00, 32'hFF11_7E3C, 4'b0000};
        vecs[7] = '{1'b1, 1'b1, 2'd0, 8'h02, 32'hFF11_7E02, 4'b0001};

        reset_n     = 1'b0;
        we          = 1'b0;
        re          = 1'b0;
        irq_mask_we = 1'b0;
        sel_port    = 2'd0;
        wdata       = 8'h00;
        in_ports    = 32'h1234_0078;
        ine_ports   = 32'hA5A5_A5A5;

        #3;
        chk("reset_out_ports", out_ports, 32'h0);
        chk("reset_strobe", {28'h0, out_strobe}, 32'h0);
        chk("reset_flags", {28'h0, chg_flags}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;

        // Nonzero static inputs across release must not raise any flag.
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("prime_flags_c%0d", i), {28'h0, chg_flags}, 32'h0);
        end
        chk("static_rdata", {24'h0, rdata}, 32'h78);
        chk("static_rdata_e", {24'h0, rdata_e}, 32'hA5);

        for (int i = 0; i < 8; i++) begin
            we          = vecs[i].we;
            irq_mask_we = vecs[i].mask_we;
            sel_port    = vecs[i].sel;
            wdata       = vecs[i].wdata;
            sb_q.push_back('{vecs[i].exp_ports, vecs[i].exp_strobe});
            tick();
            e = sb_q.pop_front();
            $display("write %0d: we=%0b sel=%0d wdata=%h -> ports=%h strobe=%b",
                     i, vecs[i].we, vecs[i].sel, vecs[i].wdata, out_ports, out_strobe);
            chk($sformatf("wr%0d_ports", i), out_ports, e.ports);
            chk($sformatf("wr%0d_strobe", i), {28'h0, out_strobe}, {28'h0, e.strobe});
        end
        we          = 1'b0;
        irq_mask_we = 1'b0;
        tick();
        chk("post_wr_strobe", {28'h0, out_strobe}, 32'h0);
        chk("post_wr_flags", {28'h0, chg_flags}, 32'h0);
        chk("post_wr_irq", {31'h0, irq}, 32'h0);

        // Port 1 main bank 0x00 -> 0x3C, mask already 0b0010.
        sel_port = 2'd1;
        in_ports[15:8] = 8'h3C;
        tick();
        chk("rd_rdata_e1", {24'h0, rdata}, 32'h00);
        tick();
        chk("rd_rdata_e2", {24'h0, rdata}, 32'h3C);
        chk("rd_flags_e2", {28'h0, chg_flags}, 32'h0);
        tick();
        chk("rd_flags_e3", {28'h0, chg_flags}, 32'h2);
        chk("irq_lag_e3", {31'h0, irq}, 32'h0);
        tick();
        chk("irq_set_e4", {31'h0, irq}, 32'h1);
        re = 1'b1;
        tick();
        re = 1'b0;
        chk("ack_flags", {28'h0, chg_flags}, 32'h0);
        chk("ack_irq_lag", {31'h0, irq}, 32'h1);
        tick();
        chk("ack_irq_clear", {31'h0, irq}, 32'h0);

        // Port 3 change lands on the same edge as its acknowledge.
        sel_port = 2'd3;
        in_ports[31:24] = 8'hC3;
        tick();
        tick();
        chk("col_flags_pre", {28'h0, chg_flags}, 32'h0);
        re = 1'b1;
        tick();
        chk("col_set_wins", {28'h0, chg_flags}, 32'h8);
        tick();
        re = 1'b0;
        chk("col_clear_after", {28'h0, chg_flags}, 32'h0);
        chk("col_irq_masked", {31'h0, irq}, 32'h0);

        // Extra bank change on port 2 (masked off).
        sel_port = 2'd2;
        ine_ports[23:16] = 8'h5A;
        tick();
        tick();
        chk("ext_rdata_e", {24'h0, rdata_e}, 32'h5A);
        chk("ext_flags_pre", {28'h0, chg_flags}, 32'h0);
        tick();
        chk("ext_flags_set", {28'h0, chg_flags}, 32'h4);
        tick();
        chk("ext_irq_masked", {31'h0, irq}, 32'h0);

        // Reset lands in the middle of a write cycle.
        we       = 1'b1;
        sel_port = 2'd0;
        wdata    = 8'hFF;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_ports", out_ports, 32'h0);
        chk("rst_async_flags", {28'h0, chg_flags}, 32'h0);
        tick();
        chk("rst_wr_ports", out_ports, 32'h0);
        chk("rst_wr_strobe", {28'h0, out_strobe}, 32'h0);
        we = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("rel_flags_c%0d", i), {28'h0, chg_flags}, 32'h0);
            chk($sformatf("rel_strobe_c%0d", i), {28'h0, out_strobe}, 32'h0);
        end
        chk("rel_ports", out_ports, 32'h0);
        chk("rel_irq", {31'h0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
